// File: rtl/stdp_pkg.sv
// Shared types, default learning-rule constants and the saturating adder
// used by the STDP weight update scheduler.
package stdp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    CALC,
    WRITE
  } state_t;

  localparam int DEF_LTP_STEP = 2;
  localparam int DEF_LTD_STEP = 1;
  localparam int DEF_W_MAX    = 127;
  localparam int DEF_W_MIN    = -128;

  // Add in a wide signed domain, then clamp to [lo, hi].
  function automatic int sat_add(input int w, input int d,
                                 input int lo = DEF_W_MIN,
                                 input int hi = DEF_W_MAX);
    int s;
    s = w + d;
    if (s > hi) return hi;
    if (s < lo) return lo;
    return s;
  endfunction

endpackage

// File: rtl/stdp_update_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first request at or after ptr, wrapping.
module rr_arbiter #(
  parameter int N  = 8,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          valid
);

  int          pos;
  logic [IW-1:0] p;

  always_comb begin
    grant = '0;
    idx   = '0;
    valid = 1'b0;
    pos   = 0;
    p     = '0;
    for (int k = 0; k < N; k++) begin
      pos = (int'(ptr) + k) % N;
      p   = IW'(pos);
      if (!valid && req[p]) begin
        valid    = 1'b1;
        idx      = p;
        grant[p] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/stdp_update_scheduler.sv
// Captures per-synapse spike events into pending flags and serves them one at
// a time as read-modify-write updates of the shared weight memory.
module stdp_update_scheduler
  import stdp_pkg::*;
#(
  parameter int N_SYN    = 8,
  parameter int W_WIDTH  = 8,
  parameter int LTP_STEP = DEF_LTP_STEP,
  parameter int LTD_STEP = DEF_LTD_STEP,
  parameter int W_MAX    = DEF_W_MAX,
  parameter int W_MIN    = DEF_W_MIN
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      learn_en,
  input  logic [N_SYN-1:0]          pre_spike,
  input  logic                      post_spike,
  output logic [$clog2(N_SYN)-1:0]  rd_addr,
  input  logic signed [W_WIDTH-1:0] rd_data,
  output logic                      wr_en,
  output logic [$clog2(N_SYN)-1:0]  wr_addr,
  output logic signed [W_WIDTH-1:0] wr_data,
  output logic                      busy,
  output logic [15:0]               upd_count
);

  localparam int IW = $clog2(N_SYN);

  state_t                     state, state_nxt;
  logic [N_SYN-1:0]           pending, ltp;
  logic [N_SYN-1:0]           cap, clr, kept;
  logic [N_SYN-1:0]           pending_nxt, ltp_nxt;
  logic [N_SYN-1:0]           gnt_onehot;
  logic [IW-1:0]              gnt_idx, sel, rr_ptr;
  logic                       gnt_vld, grant, kind;
  logic signed [W_WIDTH-1:0]  new_w, calc_w;
  int                         delta;

  rr_arbiter #(.N(N_SYN), .IW(IW)) u_arb (
    .req   (pending),
    .ptr   (rr_ptr),
    .grant (gnt_onehot),
    .idx   (gnt_idx),
    .valid (gnt_vld)
  );

  always_comb begin
    state_nxt = state;
    wr_en     = 1'b0;
    grant     = 1'b0;
    unique case (state)
      IDLE: begin
        if (gnt_vld) begin
          grant     = 1'b1;
          state_nxt = READ;
        end
      end
      READ:  state_nxt = CALC;
      CALC:  state_nxt = WRITE;
      WRITE: begin
        wr_en     = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A capture on the synapse being granted this cycle starts a fresh event,
  // so the merge only sees flags that survive the grant.
  assign cap         = learn_en ? pre_spike : '0;
  assign clr         = grant ? gnt_onehot : '0;
  assign kept        = pending & ~clr;
  assign pending_nxt = kept | cap;
  assign ltp_nxt     = (ltp & ~cap) | (cap & ((kept & ltp) | {N_SYN{post_spike}}));

  assign delta  = kind ? LTP_STEP : -LTD_STEP;
  assign calc_w = W_WIDTH'(sat_add(int'(rd_data), delta, W_MIN, W_MAX));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pending   <= '0;
      ltp       <= '0;
      rr_ptr    <= '0;
      sel       <= '0;
      kind      <= 1'b0;
      new_w     <= '0;
      rd_addr   <= '0;
      wr_addr   <= '0;
      upd_count <= '0;
    end else begin
      state   <= state_nxt;
      pending <= pending_nxt;
      ltp     <= ltp_nxt;
      if (grant) begin
        sel     <= gnt_idx;
        kind    <= ltp[gnt_idx];
        rd_addr <= gnt_idx;
      end
      if (state == CALC) begin
        new_w   <= calc_w;
        wr_addr <= sel;
      end
      if (state == WRITE) begin
        upd_count <= upd_count + 16'd1;
        rr_ptr    <= (sel == IW'(N_SYN - 1)) ? '0 : sel + IW'(1);
      end
    end
  end

  assign wr_data = new_w;
  assign busy    = (state != IDLE) || (|pending);

endmodule

// File: tb/tb_stdp_update_scheduler.sv
// Directed bench for stdp_update_scheduler with a one-cycle-latency weight memory stub.
module tb_stdp_update_scheduler;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              learn_en = 1'b0;
  logic [7:0]        pre_spike = 8'h00;
  logic              post_spike = 1'b0;
  logic [2:0]        rd_addr, wr_addr;
  logic signed [7:0] rd_data;
  logic signed [7:0] wr_data;
  logic              wr_en, busy;
  logic [15:0]       upd_count;

  logic signed [7:0] mem [8];
  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  stdp_update_scheduler dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .learn_en   (learn_en),
    .pre_spike  (pre_spike),
    .post_spike (post_spike),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .busy       (busy),
    .upd_count  (upd_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rd_data <= mem[rd_addr];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_wr(input int limit, output int n);
    n = 0;
    while (wr_en !== 1'b1 && n < limit) begin
      step();
      n++;
    end
    check("wr_en_seen", wr_en, 1);
  endtask

  task automatic single_update(input int idx, input logic post,
                               input int rdv, input int exp_w, input int exp_cnt);
    mem[idx]   = 8'(rdv);
    pre_spike  = 8'd1 << idx;
    post_spike = post;
    step();
    pre_spike  = 8'h00;
    post_spike = 1'b0;
    check("busy_rise", busy, 1);
    step();
    step();
    check("no_early_wr", wr_en, 0);
    step();
    check("wr_latency", wr_en, 1);
    check("wr_addr", wr_addr, idx);
    check("wr_data", wr_data, exp_w);
    step();
    check("wr_pulse_end", wr_en, 0);
    check("upd_count", upd_count, exp_cnt);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    logic seen;
    for (int i = 0; i < 8; i++) mem[i] = 8'sd0;

    // Reset state
    learn_en = 1'b1;
    repeat (2) step();
    check("rst_wr_en", wr_en, 0);
    check("rst_busy", busy, 0);
    check("rst_upd_count", upd_count, 0);
    check("rst_rd_addr", rd_addr, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    rst_n = 1'b1;
    step();

    // LTP, LTD at W_MIN, LTP saturating at W_MAX
    single_update(3, 1'b1, 10, 12, 1);
    check("busy_fall", busy, 0);
    single_update(5, 1'b0, -128, -128, 2);
    single_update(1, 1'b1, 126, 127, 3);

    // Burst on all synapses from a fresh pointer
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    for (int i = 0; i < 8; i++) mem[i] = 8'sd0;
    pre_spike = 8'hFF;
    step();
    pre_spike = 8'h00;
    check("burst_busy", busy, 1);
    for (int k = 0; k < 8; k++) begin
      wait_wr(20, n);
      check("burst_gap", n, 3);
      check("burst_addr", wr_addr, k);
      check("burst_data", wr_data, -1);
      step();
    end
    check("burst_busy_fall", busy, 0);
    check("burst_count", upd_count, 8);

    // Merge: pre alone then pre+post on synapse 2 while still pending
    pre_spike = 8'h05;
    step();
    pre_spike  = 8'h04;
    post_spike = 1'b1;
    step();
    pre_spike  = 8'h00;
    post_spike = 1'b0;
    wait_wr(20, n);
    check("merge_first_addr", wr_addr, 0);
    check("merge_first_data", wr_data, -1);
    step();
    wait_wr(20, n);
    check("merge_addr", wr_addr, 2);
    check("merge_data", wr_data, 2);
    seen = 1'b0;
    repeat (8) begin
      step();
      if (wr_en) seen = 1'b1;
    end
    check("merge_single_write", seen, 0);
    check("merge_count", upd_count, 10);

    // Re-spike in the grant cycle yields a second write
    mem[2]    = 8'sd5;
    pre_spike = 8'h04;
    step();
    pre_spike = 8'h04;
    step();
    pre_spike = 8'h00;
    wait_wr(20, n);
    check("respike_addr1", wr_addr, 2);
    check("respike_data1", wr_data, 4);
    step();
    wait_wr(20, n);
    check("respike_gap", n, 3);
    check("respike_addr2", wr_addr, 2);
    check("respike_data2", wr_data, 4);
    step();
    check("respike_count", upd_count, 12);
    check("respike_idle", busy, 0);

    // learn_en low blocks capture
    learn_en   = 1'b0;
    pre_spike  = 8'hFF;
    post_spike = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      step();
      if (wr_en || busy) seen = 1'b1;
    end
    pre_spike  = 8'h00;
    post_spike = 1'b0;
    check("gated_activity", seen, 0);
    check("gated_count", upd_count, 12);

    // learn_en dropped during READ: in-flight update completes
    learn_en  = 1'b1;
    pre_spike = 8'h10;
    step();
    pre_spike = 8'h00;
    step();
    learn_en = 1'b0;
    wait_wr(20, n);
    check("inflight_addr", wr_addr, 4);
    check("inflight_data", wr_data, -1);
    step();
    check("inflight_count", upd_count, 13);
    learn_en = 1'b1;

    // Reset asserted during CALC
    pre_spike  = 8'h40;
    post_spike = 1'b1;
    step();
    pre_spike  = 8'h00;
    post_spike = 1'b0;
    step();
    step();
    rst_n = 1'b0;
    #1;
    check("midrst_wr_en", wr_en, 0);
    check("midrst_busy", busy, 0);
    check("midrst_count", upd_count, 0);
    check("midrst_rd_addr", rd_addr, 0);
    check("midrst_wr_addr", wr_addr, 0);
    check("midrst_wr_data", wr_data, 0);
    step();
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      step();
      if (wr_en) seen = 1'b1;
    end
    check("midrst_no_write", seen, 0);
    check("midrst_count_after", upd_count, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/stdp_update_scheduler.md
# stdp_update_scheduler

Sequences plasticity updates for one postsynaptic neuron. Per-synapse spike events are captured into pending flags and served one at a time by round-robin arbitration. Each served event is a read-modify-write of a shared weight memory, using the team's rule: LTP +2 on a coincident pre/post spike, LTD −1 on a pre spike alone. The block sits between the synapse array's spike outputs and the weight register file, and is the only writer of learned weights.

## Interface
Parameters:
- N_SYN, 8: number of synapses; must be ≥2.
- W_WIDTH, 8: signed weight width.
- LTP_STEP, 2: magnitude added on potentiation.
- LTD_STEP, 1: magnitude subtracted on depression.
- W_MAX, 127: upper saturation bound (signed).
- W_MIN, −128: lower saturation bound (signed).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- learn_en  in  1  gates event capture only.
- pre_spike  in  N_SYN  per-synapse presynaptic spike, one-cycle pulse.
- post_spike  in  1  postsynaptic spike, shared by all synapses.
- rd_addr  out  $clog2(N_SYN)  weight memory read address.
- rd_data  in  W_WIDTH signed  weight read data, valid one cycle after rd_addr.
- wr_en  out  1  weight write strobe.
- wr_addr  out  $clog2(N_SYN)  weight write address.
- wr_data  out  W_WIDTH signed  saturated new weight.
- busy  out  1  state≠IDLE or any pending flag set.
- upd_count  out  16  number of completed writes; wraps 0xFFFF→0.

## Operation
- Capture, every cycle, for each i with learn_en & pre_spike[i]:
  - pending[i] ← 1.
  - ltp[i] ← ltp[i] | post_spike if pending[i] was already set; otherwise ltp[i] ← post_spike.
  - LTP dominates when events merge; each flag holds at most one event.
- learn_en=0 blocks capture only. Existing pending flags and the in-flight update still complete.
- FSM states are IDLE, READ, CALC, WRITE:
  - IDLE: if any pending, grant g = first set flag at or after rr_ptr (wrapping). Register sel←g and kind←ltp[g], clear pending[g], go to READ. With no flags set, stay in IDLE.
  - READ: rd_addr=sel; go to CALC.
  - CALC: sum = rd_data + (kind ? +LTP_STEP : −LTD_STEP), computed at W_WIDTH+2 bits signed and clamped to [W_MIN, W_MAX]. Register it as new_w; go to WRITE.
  - WRITE: wr_en=1, wr_addr=sel, wr_data=new_w. Increment upd_count. Set rr_ptr←(sel+1) mod N_SYN. Go to IDLE.
- A capture on synapse g in the same cycle its flag is cleared by grant re-sets the flag; the new event wins and is served later.
- rd_addr holds its last value outside READ. wr_addr and wr_data hold their last values when wr_en=0.

## Timing
- Reset values: state IDLE, pending=0, ltp=0, rr_ptr=0, sel=0, new_w=0, rd_addr=0, wr_en=0, wr_addr=0, wr_data=0, upd_count=0, busy=0.
- Event latency:
  - Event captured at edge t (flag visible in cycle t+1).
  - Grant in IDLE at t+1, READ at t+2, CALC at t+3, wr_en high during cycle t+4.
- Throughput: one update per 4 cycles. Under continuous load the FSM spends exactly one cycle in IDLE per update.
- busy is registered-state based. It rises the cycle after a capture and falls the cycle after the final WRITE when nothing is pending.
- Reset mid-update: all state clears immediately and no write is issued. Lost events are acceptable.

## Structure
- Package stdp_pkg holds:
  - state enum {IDLE, READ, CALC, WRITE}.
  - default LTP_STEP, LTD_STEP, W_MAX, W_MIN constants.
  - saturating-add function sat_add(w, d).
- Sub-module rr_arbiter (N-bit request vector plus pointer in; one-hot grant plus index and valid out) is purely combinational. The scheduler owns the pointer register.

## Test plan
- Reset, then pre_spike[3] & post_spike with rd_data=10 → wr_en at capture+4 cycles, wr_addr=3, wr_data=12, upd_count=1.
- pre_spike[5] alone with rd_data=−128 → wr_data=−128 (saturated at W_MIN). pre+post with rd_data=126 → wr_data=127.
- pre_spike=8'hFF in one cycle, post=0, all rd_data=0 → eight writes, addresses 0..7 in order, 4 cycles apart, each −1. busy falls after the 8th.
- pre_spike[2] alone, then pre_spike[2]+post while pending → single write of +2. A re-spike on synapse 2 in its grant cycle → a second write follows.
- learn_en=0 with spikes on all lines → no writes, busy=0. learn_en dropped during READ → the in-flight write still occurs.
- rst_n asserted during CALC → no wr_en pulse, all outputs at reset values, upd_count=0.
